// File: rtl/jrc_pkg.sv
// Shared types and helpers for the Johnson/ring sequence counter.
package jrc_pkg;

    typedef enum logic {
        JRC_JOHNSON = 1'b0,
        JRC_RING    = 1'b1
    } jrc_mode_e;

    typedef enum logic {
        JRC_UP   = 1'b0,
        JRC_DOWN = 1'b1
    } jrc_dir_e;

    localparam int JRC_MAX_W = 64;

    // Phase-0 pattern: all zeros for Johnson, bit0 set for ring.
    function automatic logic [JRC_MAX_W-1:0] jrc_reset_pattern(
        jrc_mode_e mode,
        int        width
    );
        logic [JRC_MAX_W-1:0] p;
        p = '0;
        if (mode == JRC_RING && width > 0)
            p[0] = 1'b1;
        return p;
    endfunction

endpackage

// File: rtl/jrc_phase_decode.sv
// Maps a counter pattern to its phase index and flags legality.
module jrc_phase_decode
    import jrc_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int PW    = $clog2(2*WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    input  logic             mode,
    output logic [PW-1:0]    phase,
    output logic             legal
);

    logic [WIDTH-1:0] inv;
    logic             thermo_lo;
    logic             thermo_hi;
    logic             onehot;
    int               ones;
    int               idx;

    always_comb begin
        inv       = ~value;
        // Low-justified run of ones, or its complement (high-justified run).
        thermo_lo = ((value & (value + WIDTH'(1))) == '0);
        thermo_hi = ((inv & (inv + WIDTH'(1))) == '0);
        onehot    = (value != '0) &&
                    ((value & (value - WIDTH'(1))) == '0);
        ones = 0;
        idx  = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                ones = ones + 1;
                idx  = i;
            end
        end
        legal = 1'b0;
        phase = '0;
        if (jrc_mode_e'(mode) == JRC_RING) begin
            legal = onehot;
            if (onehot)
                phase = PW'(idx);
        end else begin
            legal = thermo_lo || thermo_hi;
            if (legal)
                phase = value[WIDTH-1] ? PW'(2*WIDTH - ones)
                                       : PW'(ones);
        end
    end

endmodule

// File: rtl/johnson_ring_counter_p.sv
// Johnson/ring sequence counter with load, wrap and phase decode.
// Optional self-correction of illegal states: define JRC_SELF_CORRECT_EN.
module johnson_ring_counter_p
    import jrc_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int PW    = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             err
);

    jrc_mode_e        mode_i;
    jrc_mode_e        mode_q;
    logic             legal;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] rst_pat_in;
    logic [WIDTH-1:0] rst_pat_q;
    logic [PW-1:0]    last_ph;
    logic             last_hit;

    assign mode_i = jrc_mode_e'(mode);

    jrc_phase_decode #(
        .WIDTH (WIDTH)
    ) u_dec (
        .value (out),
        .mode  (mode_q),
        .phase (phase),
        .legal (legal)
    );

    always_comb begin
        rst_pat_in = WIDTH'(jrc_reset_pattern(mode_i, WIDTH));
        rst_pat_q  = WIDTH'(jrc_reset_pattern(mode_q, WIDTH));
        nxt        = out;
        unique case (1'b1)
            (mode_q == JRC_JOHNSON && dir == JRC_UP):
                nxt = {out[WIDTH-2:0], ~out[WIDTH-1]};
            (mode_q == JRC_JOHNSON && dir == JRC_DOWN):
                nxt = {~out[0], out[WIDTH-1:1]};
            (mode_q == JRC_RING && dir == JRC_UP):
                nxt = {out[WIDTH-2:0], out[WIDTH-1]};
            default:
                nxt = {out[0], out[WIDTH-1:1]};
        endcase
        last_ph  = (mode_q == JRC_RING) ? PW'(WIDTH - 1)
                                        : PW'(2*WIDTH - 1);
        // A legal state always steps to the adjacent phase.
        last_hit = legal && ((dir == JRC_DOWN) ? (phase == '0)
                                               : (phase == last_ph));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out    <= rst_pat_in;
            mode_q <= mode_i;
            wrap   <= 1'b0;
        end else if (mode_i != mode_q) begin
            out    <= rst_pat_in;
            mode_q <= mode_i;
            wrap   <= 1'b0;
        end else if (load) begin
            out  <= load_val;
            wrap <= 1'b0;
`ifdef JRC_SELF_CORRECT_EN
        end else if (!legal) begin
            out  <= rst_pat_q;
            wrap <= 1'b0;
`endif
        end else if (en) begin
            out  <= nxt;
            wrap <= last_hit;
        end else begin
            wrap <= 1'b0;
        end
    end

`ifdef JRC_SELF_CORRECT_EN
    assign err = !legal;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_ring_counter_p.sv
// Directed plus randomized checks of johnson_ring_counter_p (WIDTH=4)
// against a phase-table reference model.
module tb_johnson_ring_counter_p;

    localparam int W    = 4;
    localparam int PW   = $clog2(2*W);
    localparam int MASK = (1 << W) - 1;
`ifdef JRC_SELF_CORRECT_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          r_reset = 1'b1;
    logic          r_en = 1'b0;
    logic          r_mode = 1'b0;
    logic          r_dir = 1'b0;
    logic          r_load = 1'b0;
    logic [W-1:0]  r_lv = '0;
    logic [W-1:0]  d_out;
    logic [PW-1:0] d_phase;
    logic          d_wrap;
    logic          d_err;

    int checks = 0;
    int errors = 0;
    int m_out  = 0;
    int m_mq   = 0;
    int m_wrap = 0;
    int seq[8] = '{1, 3, 7, 15, 14, 12, 8, 0};

    johnson_ring_counter_p #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (r_reset),
        .en       (r_en),
        .mode     (r_mode),
        .dir      (r_dir),
        .load     (r_load),
        .load_val (r_lv),
        .out      (d_out),
        .phase    (d_phase),
        .wrap     (d_wrap),
        .err      (d_err)
    );

    always #5 clk = ~clk;

    function automatic int period(int md);
        return md != 0 ? W : 2*W;
    endfunction

    // Pattern shown at phase p of the sequence.
    function automatic int pat(int md, int p);
        if (md != 0)
            return 1 << p;
        if (p <= W)
            return (1 << p) - 1;
        return MASK ^ ((1 << (p - W)) - 1);
    endfunction

    function automatic int find_phase(int md, int v);
        for (int p = 0; p < period(md); p++)
            if (pat(md, p) == v)
                return p;
        return -1;
    endfunction

    function automatic int shift_raw(int md, int v, int dn);
        int fb;
        if (dn == 0) begin
            fb = (md != 0) ? (v >> (W-1)) & 1 : (~v >> (W-1)) & 1;
            return ((v << 1) & MASK) | fb;
        end
        fb = (md != 0) ? v & 1 : ~v & 1;
        return (v >> 1) | (fb << (W-1));
    endfunction

    task automatic model();
        int p;
        int per;
        p   = find_phase(m_mq, m_out);
        per = period(m_mq);
        if (r_reset || int'(r_mode) != m_mq) begin
            m_mq   = int'(r_mode);
            m_out  = pat(m_mq, 0);
            m_wrap = 0;
        end else if (r_load) begin
            m_out  = int'(r_lv);
            m_wrap = 0;
        end else if (SC && p < 0) begin
            m_out  = pat(m_mq, 0);
            m_wrap = 0;
        end else if (r_en) begin
            if (p >= 0) begin
                m_wrap = r_dir ? int'(p == 0) : int'(p == per - 1);
                m_out  = pat(m_mq, r_dir ? (p + per - 1) % per
                                         : (p + 1) % per);
            end else begin
                m_wrap = 0;
                m_out  = shift_raw(m_mq, m_out, int'(r_dir));
            end
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(string tag);
        int p;
        @(posedge clk);
        #1;
        model();
        p = find_phase(m_mq, m_out);
        chk({tag, ".out"}, 32'(d_out), 32'(m_out));
        chk({tag, ".phase"}, 32'(d_phase), 32'(p < 0 ? 0 : p));
        chk({tag, ".wrap"}, 32'(d_wrap), 32'(m_wrap));
        chk({tag, ".err"}, 32'(d_err), 32'(SC && p < 0));
    endtask

    initial begin
        // Reset in Johnson mode.
        r_reset = 1'b1; r_mode = 1'b0;
        tick("reset");
        chk("reset_out", 32'(d_out), 32'd0);
        chk("reset_wrap", 32'(d_wrap), 32'd0);

        // Johnson up through one full period.
        r_reset = 1'b0; r_en = 1'b1; r_dir = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick("j_up");
            chk("j_up_seq", 32'(d_out), 32'(seq[i]));
            chk("j_up_wrap", 32'(d_wrap), 32'(i == 7));
        end

        // Johnson down from 0000.
        r_dir = 1'b1;
        tick("j_dn");
        chk("j_dn_out", 32'(d_out), 32'h8);
        chk("j_dn_wrap", 32'(d_wrap), 32'd1);
        tick("j_dn2");
        chk("j_dn2_out", 32'(d_out), 32'hc);

        // Ring mode held through reset, then up and down.
        r_reset = 1'b1; r_mode = 1'b1;
        tick("r_reset");
        chk("r_reset_out", 32'(d_out), 32'h1);
        r_reset = 1'b0; r_dir = 1'b0;
        repeat (4) tick("r_up");
        chk("r_up_wrap", 32'(d_wrap), 32'd1);
        r_dir = 1'b1;
        tick("r_dn");
        chk("r_dn_out", 32'(d_out), 32'h8);
        chk("r_dn_wrap", 32'(d_wrap), 32'd1);
        tick("r_dn2");

        // Back to Johnson, hold, then load with en high.
        r_mode = 1'b0; r_en = 1'b0;
        tick("mode_chg");
        repeat (3) tick("hold");
        r_load = 1'b1; r_en = 1'b1; r_lv = 4'b0111;
        tick("load");
        chk("load_phase", 32'(d_phase), 32'd3);

        // Illegal Johnson pattern.
        r_lv = 4'b0101;
        tick("illegal");
        chk("illegal_phase", 32'(d_phase), 32'd0);
        r_load = 1'b0; r_dir = 1'b0;
        tick("illegal_next");
        chk("illegal_next_out", 32'(d_out), SC ? 32'h0 : 32'hb);

        // Mode change mid-count, then reset mid-count.
        r_load = 1'b1; r_lv = 4'b1110;
        tick("load5");
        r_load = 1'b0; r_mode = 1'b1;
        tick("mode_to_ring");
        chk("mode_to_ring_out", 32'(d_out), 32'h1);
        repeat (2) tick("ring_run");
        r_reset = 1'b1;
        tick("mid_reset");
        chk("mid_reset_out", 32'(d_out), 32'h1);
        r_reset = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r_reset = ($urandom_range(99) < 3);
            if ($urandom_range(99) < 5)
                r_mode = ~r_mode;
            r_load = ($urandom_range(99) < 10);
            if ($urandom_range(1) == 0)
                r_lv = W'(pat(int'(r_mode),
                              $urandom_range(period(int'(r_mode)) - 1)));
            else
                r_lv = W'($urandom_range(MASK));
            r_en  = ($urandom_range(9) < 7);
            r_dir = W'($urandom_range(1)) != '0;
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
